// File: rtl/system_widths_pkg.sv
// Shared widths, arbiter state encoding and index-width helper for mem_arbiter.
package system_widths_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // A single-core build still needs a 1-bit index to keep vectors legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting core at or after ptr, wrapping.
module rr_pick
    import system_widths_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_req_o
);

    always_comb begin
        grant_idx_o = '0;
        any_req_o   = 1'b0;
        // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_req_o && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                any_req_o   = 1'b1;
                grant_idx_o = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_req_o && req_i[i]) begin
                any_req_o   = 1'b1;
                grant_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of N core request ports onto one fixed-latency memory port.
// Optional per-core grant counters are enabled by defining ARB_STATS_EN.
module mem_arbiter
    import system_widths_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned ADDR_W  = system_widths_pkg::ADDR_W,
    parameter int unsigned DATA_W  = system_widths_pkg::DATA_W,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          we,
    input  logic [N*ADDR_W-1:0]   addr,
    input  logic [N*DATA_W-1:0]   wdata,
    output logic [N-1:0]          ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
`ifdef ARB_STATS_EN
    output logic [N*16-1:0]       grant_cnt,
`endif
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned IDX_W = idx_width(N);
    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [LAT_W-1:0]   lat_q, lat_d;

    logic [IDX_W-1:0]   grant_idx;
    logic               any_req;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lat_d   = lat_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = grant_idx;
                    state_d = ISSUE;
                    for (int unsigned i = 0; i < N; i++) begin
                        if (IDX_W'(i) == grant_idx) begin
                            we_d    = we[i];
                            addr_d  = addr[i*ADDR_W +: ADDR_W];
                            wdata_d = wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ISSUE: begin
                lat_d   = LAT_W'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                // The last WAIT cycle is exactly MEM_LAT cycles after mem_en.
                if (lat_q == LAT_W'(1)) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state_q == ISSUE);
        mem_we    = mem_en & we_q;
        mem_addr  = mem_en ? addr_q  : '0;
        mem_wdata = mem_en ? wdata_q : '0;
        rdata     = rdata_q;
        ready     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if ((state_q == RESP) && (IDX_W'(i) == idx_q)) begin
                ready[i] = 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] cnt_q [N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (ready[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter between the N per-core instruction-unit request ports (iu_miu_if side) and the single memory port inside mp_system. It accepts one outstanding request per core, grants in round-robin order, and issues exactly one memory access at a time. It returns a one-cycle ready pulse, plus read data, to the granted core after a fixed memory latency.

## Interface
- N, default 3: number of requesting cores, 1..8
- ADDR_W, default 16: address width, taken from system_widths_pkg
- DATA_W, default 8: data width
- MEM_LAT, default 2: memory read/write latency in cycles after mem_en, ≥1
- clk  in  1  single system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  N  per-core request; held until that core's ready pulse
- we  in  N  per-core write enable, qualified by req
- addr  in  N*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  N*DATA_W  per-core write data
- ready  out  N  one-cycle completion pulse to the granted core
- rdata  out  DATA_W  read data, valid in the ready cycle
- mem_en  out  1  one-cycle access strobe to memory
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  access write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, select the winner by round-robin, starting the search at ptr. Latch the winner's index, we, addr and wdata, then go to ISSUE. With no requests, stay in IDLE.
- ISSUE: drive mem_en=1 with the latched we/addr/wdata for one cycle, load lat_cnt=MEM_LAT, then go to WAIT.
- WAIT: decrement lat_cnt. When it reaches 1, capture mem_rdata into the rdata register and go to RESP.
- RESP: pulse ready[idx]=1 and set ptr=(idx+1) mod N, then go to IDLE.
- Writes take the same path and timing as reads. On a write, rdata holds the value last captured from mem_rdata and carries no meaning.
- Core protocol: a core holds req, we, addr and wdata stable until its ready pulse and drops req in the cycle after the pulse. A req still high in that cycle counts as a new request.
- If a core drops req while granted (a protocol violation), the access still completes and ready still pulses.
- Only one access is in flight; requests from other cores wait.
- N=1: ptr stays 0.

## Timing
- Reset values: ready=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, ptr=0, stats counters=0.
- Uncontended request seen in IDLE at cycle t: mem_en at t+1, ready at t+2+MEM_LAT. With MEM_LAT=2, ready is at t+4.
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Worst-case wait for a core with req held: (N−1) full accesses plus its own access.
- mem_we, mem_addr and mem_wdata are valid only while mem_en=1. They are driven to 0 otherwise.
- Reset asserted mid-access: everything returns to reset values immediately. The in-flight access is dropped with no ready pulse, and the core must reissue.

## Configuration
- ARB_STATS_EN defined: adds output grant_cnt (N*16 bits), one 16-bit counter per core. A core's counter increments on each of its ready pulses and saturates at 16'hFFFF.
- ARB_STATS_EN undefined: the grant_cnt port and its counters do not exist.

## Structure
- system_widths_pkg holds ADDR_W, DATA_W and the arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
- The sub-module rr_pick is combinational. Inputs are req[N] and ptr. Outputs are grant_idx and any_req.
- The top level holds the FSM, latches, latency counter and the optional stats logic.

## Test plan
- Reset, then core 1 reads 16'h0010 (memory preloaded with 8'hA5) → mem_en pulses 1 cycle after the request is sampled; ready[1] and rdata=8'hA5 follow MEM_LAT+1 cycles after that.
- Core 0 writes 8'h3C to 16'h0004, then reads 16'h0004 → mem_we=1 on the first access; the read returns 8'h3C.
- All three cores request in the same cycle after reset → ready pulses come in order 0,1,2, spaced MEM_LAT+3 cycles apart.
- Core 2 holds req continuously while cores 0 and 1 alternate → no core is granted twice before each other waiting core gets one grant.
- Reset asserted during WAIT → outputs go to 0 the same cycle, no ready pulse appears, and a reissued request completes normally.
- With ARB_STATS_EN, 200 random transactions → sum of grant_cnt = 200, and each core's count equals its scoreboard count.
